// File: rtl/prog_timer_core.sv
// Dual programmable interval timer: two identical 8-bit counters written a nibble at a time,
// with one-shot, rate-generator, square-wave and disabled modes.
module prog_timer_core (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d,
    input  logic [1:0] a,
    input  logic       g0,
    input  logic       g1,
    output logic       out0,
    output logic       out1
);

    typedef enum logic [1:0] {
        StEmpty    = 2'd0,
        StArmed    = 2'd1,
        StCounting = 2'd2
    } state_e;

    localparam logic [1:0] ModeOneShot = 2'b00;
    localparam logic [1:0] ModeRate    = 2'b01;
    localparam logic [1:0] ModeSquare  = 2'b10;
    localparam logic [1:0] AddrCtrl    = 2'b10;

    // Counts use 0 to encode 256, so plain 8-bit wrap-around decrement is exact.
    logic [7:0] n_q[2], n_d[2];
    logic [7:0] c_q[2], c_d[2];
    logic [7:0] half_q[2], half_d[2];
    logic [1:0] m_q[2], m_d[2];
    logic       p_q[2], p_d[2];
    logic       gh_q[2], gh_d[2];
    logic       out_q[2], out_d[2];
    state_e     st_q[2], st_d[2];

    logic [1:0] gate;
    assign gate = {g1, g0};

    always_comb begin
        logic [7:0] neff;
        logic [7:0] half;
        logic [7:0] c_next;
        logic       rise;
        logic       reload;
        for (int i = 0; i < 2; i++) begin
            n_d[i]    = n_q[i];
            c_d[i]    = c_q[i];
            half_d[i] = half_q[i];
            m_d[i]    = m_q[i];
            p_d[i]    = p_q[i];
            out_d[i]  = out_q[i];
            st_d[i]   = st_q[i];
            gh_d[i]   = gate[i];

            rise = gate[i] & ~gh_q[i];
            if (n_q[i] == 8'd1 && (m_q[i] == ModeRate || m_q[i] == ModeSquare)) begin
                neff = 8'd2;
            end else begin
                neff = n_q[i];
            end
            half   = (neff == 8'd0) ? 8'd128 : {1'b0, neff[7:1]};
            reload = (c_q[i] == 8'd1);
            c_next = reload ? neff : c_q[i] - 8'd1;

            if (a == AddrCtrl && d[3] == 1'(i)) begin
                m_d[i]   = d[2:1];
                p_d[i]   = 1'b0;
                st_d[i]  = StEmpty;
                out_d[i] = 1'b1;
            end else begin
                if (a == 2'(i)) begin
                    if (!p_q[i]) begin
                        n_d[i][3:0] = d;
                        p_d[i]      = 1'b1;
                    end else begin
                        n_d[i][7:4] = d;
                        p_d[i]      = 1'b0;
                        if (st_q[i] == StEmpty) st_d[i] = StArmed;
                    end
                end

                case (m_q[i])
                    ModeOneShot: begin
                        if (st_q[i] != StEmpty && rise) begin
                            c_d[i]   = neff;
                            out_d[i] = 1'b0;
                            st_d[i]  = StCounting;
                        end else if (st_q[i] == StCounting) begin
                            c_d[i] = c_q[i] - 8'd1;
                            if (reload) begin
                                out_d[i] = 1'b1;
                                st_d[i]  = StArmed;
                            end
                        end
                    end
                    ModeRate, ModeSquare: begin
                        if (st_q[i] == StArmed && gate[i]) begin
                            st_d[i]   = StCounting;
                            c_d[i]    = neff;
                            half_d[i] = half;
                            out_d[i]  = 1'b1;
                        end else if (st_q[i] == StCounting) begin
                            if (gate[i]) begin
                                c_d[i] = c_next;
                                if (reload) half_d[i] = half;
                                if (m_q[i] == ModeRate) begin
                                    out_d[i] = ~reload;
                                end else begin
                                    // High while the remaining count is above half the period.
                                    out_d[i] = (c_next == 8'd0) ||
                                               (c_next > (reload ? half : half_q[i]));
                                end
                            end else begin
                                out_d[i] = 1'b1;
                            end
                        end
                    end
                    default: out_d[i] = 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                n_q[i]    <= 8'd0;
                c_q[i]    <= 8'd0;
                half_q[i] <= 8'd0;
                m_q[i]    <= 2'b11;
                p_q[i]    <= 1'b0;
                gh_q[i]   <= 1'b0;
                out_q[i]  <= 1'b1;
                st_q[i]   <= StEmpty;
            end else begin
                n_q[i]    <= n_d[i];
                c_q[i]    <= c_d[i];
                half_q[i] <= half_d[i];
                m_q[i]    <= m_d[i];
                p_q[i]    <= p_d[i];
                gh_q[i]   <= gh_d[i];
                out_q[i]  <= out_d[i];
                st_q[i]   <= st_d[i];
            end
        end
    end

    assign out0 = out_q[0];
    assign out1 = out_q[1];

endmodule

// File: tb/tb_prog_timer_core.sv
// Bench for prog_timer_core: directed scenarios plus random traffic, all checked against a
// cycle-level reference model that tracks periods and phases in plain integers.
module tb_prog_timer_core;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] d;
    logic [1:0] a;
    logic       g0, g1;
    logic       out0, out1;

    prog_timer_core u_dut (
        .clk  (clk),
        .rst  (rst),
        .d    (d),
        .a    (a),
        .g0   (g0),
        .g1   (g1),
        .out0 (out0),
        .out1 (out1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int lows0  = 0;
    int lows1  = 0;

    // Reference model state; st: 0 empty, 1 armed, 2 counting.
    int m_n[2], m_mode[2], m_p[2], m_st[2], m_gp[2], m_out[2];
    int m_per[2], m_ph[2], m_len[2], m_el[2];

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int eff(input int n, input int mode);
        if (n == 0) return 256;
        if (n == 1 && (mode == 1 || mode == 2)) return 2;
        return n;
    endfunction

    task automatic model_step(input bit r, input int aa, input int dd, input bit gv[2]);
        for (int i = 0; i < 2; i++) begin
            int old_st, old_n;
            bit rise;
            if (r) begin
                m_n[i] = 0; m_mode[i] = 3; m_p[i] = 0; m_st[i] = 0; m_gp[i] = 0; m_out[i] = 1;
                continue;
            end
            rise   = gv[i] && (m_gp[i] == 0);
            old_st = m_st[i];
            old_n  = m_n[i];
            if (aa == 2 && ((dd >> 3) & 1) == i) begin
                m_mode[i] = (dd >> 1) & 3;
                m_p[i]    = 0;
                m_st[i]   = 0;
                m_out[i]  = 1;
            end else begin
                if (aa == i) begin
                    if (m_p[i] == 0) begin
                        m_n[i] = (m_n[i] & 8'hf0) | dd;
                        m_p[i] = 1;
                    end else begin
                        m_n[i] = (m_n[i] & 8'h0f) | (dd << 4);
                        m_p[i] = 0;
                        if (m_st[i] == 0) m_st[i] = 1;
                    end
                end
                if (m_mode[i] == 0) begin
                    if (old_st != 0 && rise) begin
                        m_len[i] = eff(old_n, 0);
                        m_el[i]  = 1;
                        m_out[i] = 0;
                        m_st[i]  = 2;
                    end else if (old_st == 2) begin
                        if (m_el[i] == m_len[i]) begin
                            m_out[i] = 1;
                            m_st[i]  = 1;
                        end else begin
                            m_el[i]++;
                        end
                    end
                end else if (m_mode[i] == 1 || m_mode[i] == 2) begin
                    if (old_st == 1 && gv[i]) begin
                        m_st[i]  = 2;
                        m_per[i] = eff(old_n, m_mode[i]);
                        m_ph[i]  = 0;
                        m_out[i] = 1;
                    end else if (old_st == 2) begin
                        if (gv[i]) begin
                            bit wrapped;
                            m_ph[i]++;
                            wrapped = (m_ph[i] == m_per[i]);
                            if (wrapped) begin
                                m_ph[i]  = 0;
                                m_per[i] = eff(old_n, m_mode[i]);
                            end
                            if (m_mode[i] == 1) m_out[i] = wrapped ? 0 : 1;
                            else m_out[i] = (m_ph[i] < (m_per[i] + 1) / 2) ? 1 : 0;
                        end else begin
                            m_out[i] = 1;
                        end
                    end
                end else begin
                    m_out[i] = 1;
                end
            end
            m_gp[i] = gv[i];
        end
    endtask

    task automatic cyc(input bit r, input int aa, input int dd, input bit gg0, input bit gg1);
        bit gv[2];
        rst = r; a = 2'(aa); d = 4'(dd); g0 = gg0; g1 = gg1;
        gv[0] = gg0; gv[1] = gg1;
        @(posedge clk);
        model_step(r, aa, dd, gv);
        #1;
        check_eq("out0", {15'd0, out0}, 16'(m_out[0]));
        check_eq("out1", {15'd0, out1}, 16'(m_out[1]));
        if (out0 === 1'b0) lows0++;
        if (out1 === 1'b0) lows1++;
    endtask

    task automatic idle(input bit gg0, input bit gg1, input int n);
        for (int k = 0; k < n; k++) cyc(0, 3, 0, gg0, gg1);
    endtask

    task automatic wr_n(input int ctr, input int val, input bit gg0, input bit gg1);
        cyc(0, ctr, val & 4'hf, gg0, gg1);
        cyc(0, ctr, (val >> 4) & 4'hf, gg0, gg1);
    endtask

    initial begin
        bit gr0, gr1;
        rst = 1'b1; a = 2'b11; d = 4'h0; g0 = 1'b0; g1 = 1'b0;
        cyc(1, 3, 0, 0, 0);
        check_eq("rst_out0", {15'd0, out0}, 16'd1);
        check_eq("rst_out1", {15'd0, out1}, 16'd1);

        // Counter0 rate generator, N=4.
        cyc(0, 2, 4'b0010, 0, 0);
        wr_n(0, 4, 0, 0);
        idle(1, 0, 1);
        lows0 = 0;
        idle(1, 0, 16);
        check_eq("rate4_pulses", 16'(lows0), 16'd4);

        // Counter1 square wave, N=5; counter0 frozen.
        cyc(0, 2, 4'b1100, 0, 0);
        wr_n(1, 5, 0, 0);
        idle(0, 1, 1);
        lows0 = 0; lows1 = 0;
        idle(0, 1, 10);
        check_eq("sq5_lows", 16'(lows1), 16'd4);
        check_eq("frozen0_lows", 16'(lows0), 16'd0);

        // Counter0 one-shot N=6 with retrigger on the fourth cycle.
        cyc(0, 2, 4'b0000, 0, 0);
        wr_n(0, 6, 0, 0);
        idle(0, 0, 2);
        lows0 = 0;
        cyc(0, 3, 0, 1, 0);
        cyc(0, 3, 0, 1, 0);
        cyc(0, 3, 0, 0, 0);
        cyc(0, 3, 0, 1, 0);
        idle(1, 0, 10);
        check_eq("oneshot_low", 16'(lows0), 16'd9);

        // Rate generator N=8 with gate dropped mid-count.
        cyc(0, 2, 4'b0010, 0, 0);
        wr_n(0, 8, 0, 0);
        idle(1, 0, 5);
        lows0 = 0;
        idle(0, 0, 3);
        check_eq("gate_low_quiet", 16'(lows0), 16'd0);
        idle(1, 0, 20);

        // Reload changes while running: N=4 -> 2 -> 0 (256) -> 1 (2).
        cyc(0, 2, 4'b0010, 0, 0);
        wr_n(0, 4, 0, 0);
        idle(1, 0, 6);
        wr_n(0, 2, 1, 0);
        idle(1, 0, 12);
        wr_n(0, 0, 1, 0);
        idle(1, 0, 530);
        wr_n(0, 1, 1, 0);
        lows0 = 0;
        idle(1, 0, 300);
        check_eq("n1_after_256", 16'(lows0 >= 20 && lows0 <= 150), 16'd1);

        // Reset mid-count on both counters, then gates ignored.
        cyc(0, 2, 4'b1010, 1, 0);
        wr_n(1, 3, 1, 0);
        idle(1, 1, 5);
        cyc(1, 3, 0, 1, 1);
        check_eq("midrst_out0", {15'd0, out0}, 16'd1);
        check_eq("midrst_out1", {15'd0, out1}, 16'd1);
        lows0 = 0; lows1 = 0;
        for (int k = 0; k < 12; k++) cyc(0, 3, 0, k[0], ~k[0]);
        check_eq("post_rst_quiet", 16'(lows0 + lows1), 16'd0);

        // Random traffic.
        gr0 = 0; gr1 = 0;
        for (int k = 0; k < 4000; k++) begin
            int sel, aa;
            if ($urandom_range(7) == 0) gr0 = ~gr0;
            if ($urandom_range(7) == 0) gr1 = ~gr1;
            sel = int'($urandom_range(15));
            if (sel == 0) aa = 2;
            else if (sel <= 2) aa = 0;
            else if (sel <= 4) aa = 1;
            else aa = 3;
            cyc($urandom_range(299) == 0, aa, int'($urandom_range(15)), gr0, gr1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
